pbit_group_scheduler: RTL and testbench
=======================================

Name: pbit_group_scheduler

Overview:
- Sequential successor to the fixed group-to-enable lookup used in the p-bit arrays.
- Holds one programmable enable mask per colour group in registers and cycles through the groups autonomously, so only non-interacting p-bits update together.
- Supports a programmable per-group dwell time and a runtime-selectable active group count.
- Counts completed sweeps for the annealing controller; sits between the controller and the p-bit array enable inputs.

Parameters:
N_PBITS, 223, number of p-bits / width of enable mask
N_GROUPS, 4, maximum number of colour groups (mask registers)
GRP_W, 2, width of group index, equals clog2(N_GROUPS)
DWELL_W, 8, width of dwell counter
SWEEP_W, 16, width of sweep counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  1 = schedule groups, 0 = stop and go idle
cfg_we  input  1  write strobe for mask register file
cfg_group  input  GRP_W  mask register index to write
cfg_mask  input  N_PBITS  mask data
num_groups  input  GRP_W+1  active group count, sampled at sweep start
dwell  input  DWELL_W  extra cycles each group stays enabled (dwell+1 cycles total)
Pbit_EN  output  N_PBITS  registered enable mask to the p-bit array
group_idx  output  GRP_W  group currently driven on Pbit_EN
busy  output  1  high while in ACTIVE or GAP
sweep_done  output  1  one-cycle pulse at end of each full sweep
sweep_count  output  SWEEP_W  completed sweeps, wraps at 2^SWEEP_W

Behaviour:
- Clock and reset: one clock domain; clk, synchronous active-high rst.
- Reset values: all mask registers 0, Pbit_EN 0, group_idx 0, busy 0, sweep_done 0, sweep_count 0, FSM in IDLE, dwell counter 0.
- Mask writes:
  - When cfg_we=1, mask[cfg_group] <= cfg_mask at the clock edge. Writes are accepted in every state.
  - A write to the group currently active takes effect on Pbit_EN from the next cycle.
  - cfg_group >= N_GROUPS: write is ignored.
- Effective group count G: G = num_groups, clamped so that 0 becomes 1 and values > N_GROUPS become N_GROUPS. G is latched on entry to group 0 of each sweep; changes mid-sweep take effect at the next sweep.
- FSM IDLE:
  - Pbit_EN = 0, busy = 0.
  - On run=1, go to ACTIVE with group_idx = 0. Pbit_EN = mask[0] on the cycle after run is sampled high (1-cycle latency).
- FSM ACTIVE:
  - Pbit_EN = mask[group_idx] for dwell+1 consecutive cycles. dwell is sampled when the group is entered.
  - At the end of the dwell, advance group_idx. After group G-1, group_idx wraps to 0, sweep_done pulses on the last cycle of group G-1, and sweep_count increments on the same edge.
  - With G=1 and dwell=0, mask[0] stays continuously asserted and sweep_done pulses every cycle.
- Run deassert: run=0 in any state sends the FSM to IDLE on the next edge. Pbit_EN = 0, group_idx = 0, dwell counter cleared, and no sweep_done for the partial sweep. sweep_count is held, not cleared.
- rst mid-operation: overrides everything and restores all reset values, including masks.
- Simultaneous events:
  - run=0 coinciding with a sweep end: run=0 wins and no pulse is issued.
  - cfg_we coinciding with a group advance: the new group's Pbit_EN uses the newly written mask if cfg_group equals the new group index.
- sweep_count wrap: wraps from 2^SWEEP_W-1 to 0 with no flag.

Optional Feature:
- Macro: PBIT_GAP_CYCLE_EN.
- When defined: adds FSM state GAP. After each group's dwell ends, one cycle with Pbit_EN = 0 is inserted for settling; group_idx already shows the next group; busy stays 1. sweep_done and the sweep_count increment occur on the last ACTIVE cycle of group G-1, not in the GAP cycle.
- When undefined: no GAP state and groups are back-to-back. Sweep period = G*(dwell+1) cycles without the macro, G*(dwell+2) with it.

Test Plan:
- Reset, then write mask[0]=..0F, mask[1]=..F0, mask[2]=0xF00, mask[3]=0xF000; num_groups=4, dwell=0, run=1 -> Pbit_EN cycles 0x000F,0x00F0,0x0F00,0xF000 repeating; sweep_done every 4 cycles; sweep_count=3 after 12 active cycles.
- dwell=2, num_groups=3 -> each mask is held 3 cycles; group 3 is never driven; period = 9 cycles.
- num_groups=0 and num_groups=7 -> behaves as G=1 and G=4 respectively.
- Drop run in the middle of group 2 -> Pbit_EN=0 and group_idx=0 next cycle; sweep_count unchanged. Re-asserting run restarts at group 0.
- Write mask[1]=0x1 while group 1 is active -> Pbit_EN=0x1 on the following cycle. A write with cfg_group beyond N_GROUPS leaves all masks unchanged.
- With PBIT_GAP_CYCLE_EN defined, dwell=0, G=2 -> Pbit_EN pattern mask0,0,mask1,0; period 4 cycles. Assert rst mid-sweep -> all outputs 0 and masks cleared.

Source files
------------

// File: rtl/pbit_group_scheduler.sv
// pbit_group_scheduler: steps through per-colour-group enable masks onto a p-bit array and counts sweeps.
// Optional macro PBIT_GAP_CYCLE_EN inserts one all-off settling cycle between consecutive groups.
module pbit_group_scheduler #(
  parameter int N_PBITS  = 223,
  parameter int N_GROUPS = 4,
  parameter int GRP_W    = 2,
  parameter int DWELL_W  = 8,
  parameter int SWEEP_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cfg_we,
  input  logic [GRP_W-1:0]   cfg_group,
  input  logic [N_PBITS-1:0] cfg_mask,
  input  logic [GRP_W:0]     num_groups,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_PBITS-1:0] Pbit_EN,
  output logic [GRP_W-1:0]   group_idx,
  output logic               busy,
  output logic               sweep_done,
  output logic [SWEEP_W-1:0] sweep_count
);

`ifdef PBIT_GAP_CYCLE_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  state_t             state;
  logic [N_PBITS-1:0] mask [N_GROUPS];
  logic [DWELL_W-1:0] remaining;
  logic [GRP_W:0]     grp_cnt;

  logic [GRP_W:0]     grp_cnt_new;
  logic [GRP_W-1:0]   last_grp;
  logic [GRP_W-1:0]   next_grp;
  logic [GRP_W-1:0]   enter_grp;
  logic [GRP_W-1:0]   enter_last;
  logic               enter_pulse;
  logic               hold_pulse;
  logic [N_PBITS-1:0] enter_mask;
  logic [N_PBITS-1:0] hold_mask;

  always_comb begin
    grp_cnt_new = num_groups;
    if (num_groups == '0)
      grp_cnt_new = (GRP_W+1)'(1);
    else if (num_groups > (GRP_W+1)'(N_GROUPS))
      grp_cnt_new = (GRP_W+1)'(N_GROUPS);
  end

  assign last_grp = GRP_W'(grp_cnt - 1'b1);
  assign next_grp = (group_idx == last_grp) ? '0 : group_idx + 1'b1;

  // Group about to be entered on this edge; entering group 0 uses the freshly clamped count.
  always_comb begin
    enter_grp = '0;
    if (state == ACTIVE)
      enter_grp = next_grp;
`ifdef PBIT_GAP_CYCLE_EN
    else if (state == GAP)
      enter_grp = group_idx;
`endif
  end

  assign enter_last  = (enter_grp == '0) ? GRP_W'(grp_cnt_new - 1'b1) : last_grp;
  assign enter_pulse = (dwell == '0) && (enter_grp == enter_last);
  assign hold_pulse  = (remaining == DWELL_W'(1)) && (group_idx == last_grp);

  // A mask written on the same edge is forwarded so the new value reaches Pbit_EN immediately.
  always_comb begin
    enter_mask = '0;
    hold_mask  = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (enter_grp == GRP_W'(g)) enter_mask = mask[g];
      if (group_idx == GRP_W'(g)) hold_mask = mask[g];
    end
    if (cfg_we && cfg_group == enter_grp) enter_mask = cfg_mask;
    if (cfg_we && cfg_group == group_idx) hold_mask = cfg_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < N_GROUPS; g++) mask[g] <= '0;
      state       <= IDLE;
      Pbit_EN     <= '0;
      group_idx   <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      sweep_count <= '0;
      remaining   <= '0;
      grp_cnt     <= (GRP_W+1)'(1);
    end else begin
      for (int g = 0; g < N_GROUPS; g++)
        if (cfg_we && cfg_group == GRP_W'(g)) mask[g] <= cfg_mask;
      sweep_done <= 1'b0;
      if (!run) begin
        state     <= IDLE;
        Pbit_EN   <= '0;
        group_idx <= '0;
        remaining <= '0;
        busy      <= 1'b0;
      end else if (state == ACTIVE && remaining != '0) begin
        remaining <= remaining - 1'b1;
        Pbit_EN   <= hold_mask;
        if (hold_pulse) begin
          sweep_done  <= 1'b1;
          sweep_count <= sweep_count + 1'b1;
        end
      end
`ifdef PBIT_GAP_CYCLE_EN
      else if (state == ACTIVE) begin
        state     <= GAP;
        group_idx <= next_grp;
        Pbit_EN   <= '0;
      end
`endif
      else begin
        // The sweep pulse is registered so it coincides with the final cycle of the last group.
        state     <= ACTIVE;
        busy      <= 1'b1;
        group_idx <= enter_grp;
        remaining <= dwell;
        Pbit_EN   <= enter_mask;
        if (enter_grp == '0) grp_cnt <= grp_cnt_new;
        if (enter_pulse) begin
          sweep_done  <= 1'b1;
          sweep_count <= sweep_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pbit_group_scheduler.sv
// tb_pbit_group_scheduler: directed and randomized checks against a per-cycle schedule-queue model.
module tb_pbit_group_scheduler;
  localparam int N_PBITS  = 223;
  localparam int N_GROUPS = 4;
  localparam int GRP_W    = 2;
  localparam int DWELL_W  = 8;
  localparam int SWEEP_W  = 16;
`ifdef PBIT_GAP_CYCLE_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               cfg_we;
  logic [GRP_W-1:0]   cfg_group;
  logic [N_PBITS-1:0] cfg_mask;
  logic [GRP_W:0]     num_groups;
  logic [DWELL_W-1:0] dwell;
  logic [N_PBITS-1:0] Pbit_EN;
  logic [GRP_W-1:0]   group_idx;
  logic               busy;
  logic               sweep_done;
  logic [SWEEP_W-1:0] sweep_count;

  pbit_group_scheduler #(
    .N_PBITS(N_PBITS), .N_GROUPS(N_GROUPS), .GRP_W(GRP_W),
    .DWELL_W(DWELL_W), .SWEEP_W(SWEEP_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_group(cfg_group),
    .cfg_mask(cfg_mask), .num_groups(num_groups), .dwell(dwell),
    .Pbit_EN(Pbit_EN), .group_idx(group_idx), .busy(busy),
    .sweep_done(sweep_done), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  // Each queue entry is one future output cycle; an empty queue means idle.
  typedef struct {
    int grp;
    bit gap;
    bit last;
  } slot_t;

  slot_t              sched[$];
  int                 mdl_g = 1;
  logic [SWEEP_W-1:0] mdl_count = '0;
  logic [N_PBITS-1:0] mdl_mask [N_GROUPS];

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  function automatic int clamp_groups(input int n);
    if (n == 0) return 1;
    if (n > N_GROUPS) return N_GROUPS;
    return n;
  endfunction

  function automatic logic [N_PBITS-1:0] rand_mask();
    logic [N_PBITS-1:0] r;
    for (int i = 0; i < N_PBITS; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic fill_active(input int g);
    if (g == 0) mdl_g = clamp_groups(int'(num_groups));
    for (int i = 0; i <= int'(dwell); i++)
      sched.push_back('{g, 1'b0, (g == mdl_g - 1) && (i == int'(dwell))});
  endtask

  task automatic modelEdge();
    slot_t cur;
    int    ng;
    if (rst) begin
      for (int g = 0; g < N_GROUPS; g++) mdl_mask[g] = '0;
      sched.delete();
      mdl_count = '0;
      return;
    end
    if (cfg_we && int'(cfg_group) < N_GROUPS) mdl_mask[cfg_group] = cfg_mask;
    if (!run) begin
      sched.delete();
      return;
    end
    if (sched.size() == 0) begin
      fill_active(0);
    end else begin
      cur = sched.pop_front();
      if (sched.size() == 0) begin
        if (cur.gap) begin
          fill_active(cur.grp);
        end else begin
          ng = (cur.grp == mdl_g - 1) ? 0 : cur.grp + 1;
          if (GAP_EN) sched.push_back('{ng, 1'b1, 1'b0});
          else fill_active(ng);
        end
      end
    end
    if (sched[0].last) mdl_count = mdl_count + 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    logic [N_PBITS-1:0] exp_en;
    logic [GRP_W-1:0]   exp_idx;
    logic               exp_busy;
    logic               exp_done;
    exp_en = '0; exp_idx = '0; exp_busy = 1'b0; exp_done = 1'b0;
    if (sched.size() != 0) begin
      exp_en   = sched[0].gap ? '0 : mdl_mask[sched[0].grp];
      exp_idx  = GRP_W'(sched[0].grp);
      exp_busy = 1'b1;
      exp_done = sched[0].last;
    end
    check_count += 5;
    assert (Pbit_EN === exp_en) begin pass_count++; end
    else begin fail_count++; $error("FAIL %s Pbit_EN: observed %h expected %h (#%0d)", tag, Pbit_EN, exp_en, fail_count); end
    assert (group_idx === exp_idx) begin pass_count++; end
    else begin fail_count++; $error("FAIL %s group_idx: observed %0d expected %0d (#%0d)", tag, group_idx, exp_idx, fail_count); end
    assert (busy === exp_busy) begin pass_count++; end
    else begin fail_count++; $error("FAIL %s busy: observed %b expected %b (#%0d)", tag, busy, exp_busy, fail_count); end
    assert (sweep_done === exp_done) begin pass_count++; end
    else begin fail_count++; $error("FAIL %s sweep_done: observed %b expected %b (#%0d)", tag, sweep_done, exp_done, fail_count); end
    assert (sweep_count === mdl_count) begin pass_count++; end
    else begin fail_count++; $error("FAIL %s sweep_count: observed %0d expected %0d (#%0d)", tag, sweep_count, mdl_count, fail_count); end
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic we,
                               input logic [GRP_W-1:0] grp, input logic [N_PBITS-1:0] m,
                               input logic [GRP_W:0] ng, input logic [DWELL_W-1:0] dw,
                               input string tag);
    rst = r; run = rn; cfg_we = we; cfg_group = grp; cfg_mask = m;
    num_groups = ng; dwell = dw;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  function automatic bit in_group(input int g);
    return sched.size() != 0 && !sched[0].gap && sched[0].grp == g;
  endfunction

  initial begin
    for (int g = 0; g < N_GROUPS; g++) mdl_mask[g] = '0;
    rst = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_group = '0; cfg_mask = '0;
    num_groups = '0; dwell = '0;

    $display("[TB] reset and mask programming");
    applyStimulus(1, 0, 0, 0, '0, 0, 0, "reset");
    applyStimulus(1, 1, 1, 2, rand_mask(), 4, 0, "reset_override");
    applyStimulus(0, 0, 1, 0, N_PBITS'('h000F), 4, 0, "wr_mask0");
    applyStimulus(0, 0, 1, 1, N_PBITS'('h00F0), 4, 0, "wr_mask1");
    applyStimulus(0, 0, 1, 2, N_PBITS'('h0F00), 4, 0, "wr_mask2");
    applyStimulus(0, 0, 1, 3, N_PBITS'('hF000), 4, 0, "wr_mask3");

    $display("[TB] four groups, no dwell");
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0, '0, 4, 0, "g4_d0");

    $display("[TB] three groups, dwell 2");
    for (int i = 0; i < 22; i++) applyStimulus(0, 1, 0, 0, '0, 3, 2, "g3_d2");

    $display("[TB] group count clamping");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, '0, 0, 0, "ng0");
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0, '0, 7, 0, "ng7");

    $display("[TB] drop run inside group 2, then restart");
    applyStimulus(0, 0, 0, 0, '0, 4, 1, "idle_before_drop");
    for (int i = 0; i < 20 && !in_group(2); i++) applyStimulus(0, 1, 0, 0, '0, 4, 1, "seek_g2");
    applyStimulus(0, 0, 0, 0, '0, 4, 1, "run_drop");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, '0, 4, 1, "restart");

    $display("[TB] live write to active group");
    for (int i = 0; i < 20 && !in_group(1); i++) applyStimulus(0, 1, 0, 0, '0, 4, 3, "seek_g1");
    applyStimulus(0, 1, 1, 1, N_PBITS'('h1), 4, 3, "live_write");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, '0, 4, 3, "after_live_write");

    $display("[TB] two groups and reset mid-sweep");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, '0, 2, 0, "g2_d0");
    applyStimulus(1, 1, 0, 0, '0, 2, 0, "mid_reset");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, '0, 2, 0, "masks_cleared");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 15) != 0,
                    $urandom_range(0, 3) == 0, GRP_W'($urandom_range(0, 3)), rand_mask(),
                    (GRP_W+1)'($urandom_range(0, 7)), DWELL_W'($urandom_range(0, 3)), "random");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
